ulpi_init_seq: RTL

Power-up configuration sequencer for the USB3300 PHY in the sniffer design. It sits between the top level and the ULPI controller and drives the controller's register-write and register-read request interface. It walks a fixed table of PHY register writes that puts the PHY into non-driving, pull-down-free HS listen mode, optionally reading back each register to check it. Completion and failure are reported to the top level so capture logic stays gated until the PHY is configured.

---
 rtl/ulpi_pkg.sv | 39 +++
 rtl/ulpi_init_timer.sv | 24 ++
 rtl/ulpi_init_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_pkg.sv
// Shared definitions for the USB3300 power-up sequencer: FSM states, PHY register
// addresses, the init table and error codes.
package ulpi_pkg;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StPorw  = 4'd1,
        StWrReq = 4'd2,
        StWrAck = 4'd3,
        StWrEnd = 4'd4,
        StRdReq = 4'd5,
        StRdAck = 4'd6,
        StRdEnd = 4'd7,
        StCheck = 4'd8,
        StNext  = 4'd9,
        StDone  = 4'd10,
        StError = 4'd11
    } init_state_t;

    localparam logic [5:0] RegFuncCtrl = 6'h04;
    localparam logic [5:0] RegIfcCtrl  = 6'h07;
    localparam logic [5:0] RegOtgCtrl  = 6'h0A;
    localparam logic [5:0] RegScratch  = 6'h16;

    // Entry 0 is the least significant element; entries are issued 0..3.
    localparam logic [3:0][5:0] InitAddr = {RegFuncCtrl, RegIfcCtrl, RegOtgCtrl, RegScratch};
    localparam logic [3:0][7:0] InitData = {8'h48, 8'h00, 8'h00, 8'hA5};

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrAccept   = 2'b01;
    localparam logic [1:0] ErrComplete = 2'b10;
    localparam logic [1:0] ErrVerify   = 2'b11;

    // The timer flags zero after (value + 1) cycles, so a wait of N cycles loads N-1.
    function automatic logic [15:0] load_value(input logic [15:0] cycles);
        return (cycles == 16'd0) ? 16'd0 : cycles - 16'd1;
    endfunction

endpackage

// File: rtl/ulpi_init_timer.sv
// Loadable down-counter shared by the power-on wait and the per-phase watchdog.
module ulpi_init_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    output logic        zero
);

    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 16'd0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != 16'd0) begin
            count_q <= count_q - 16'd1;
        end
    end

    assign zero = (count_q == 16'd0);

endmodule

// File: rtl/ulpi_init_seq.sv
// USB3300 power-up register sequencer driving the ULPI controller request port.
// Define ULPI_INIT_VERIFY_EN to compile in read-back verification of each entry.
module ulpi_init_seq
    import ulpi_pkg::*;
#(
    parameter logic [15:0] POR_WAIT   = 16'd1000,
    parameter logic [7:0]  TIMEOUT    = 8'd255,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic       clk_ext,
    input  logic       rst,
    input  logic       start,
    input  logic       DIR,
    input  logic       BUSY,
    input  logic [7:0] REG_DATA_OUT,
    output logic       WD,
    output logic       RD,
    output logic [5:0] ADDR,
    output logic [7:0] REG_DATA_IN,
    output logic       running,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [1:0] err_idx
);

    localparam logic [15:0] PorLoad = load_value(POR_WAIT);
    localparam logic [15:0] WdLoad  = load_value({8'd0, TIMEOUT});

    init_state_t state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        auto_q;
    logic        wd_q, wd_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        running_q, running_d;
    logic        done_q, error_q;
    logic [1:0]  err_code_q, err_code_d;
    logic [1:0]  err_idx_q, err_idx_d;

    logic        tmr_load;
    logic [15:0] tmr_value;
    logic        tmr_zero;

`ifdef ULPI_INIT_VERIFY_EN
    logic       rd_q, rd_d;
    logic [7:0] rd_data_q, rd_data_d;
`endif

    ulpi_init_timer u_timer (
        .clk   (clk_ext),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    // Every state change restarts the timer: PORW gets the power-on wait, all else the watchdog.
    assign tmr_load  = (state_d != state_q);
    assign tmr_value = (state_d == StPorw) ? PorLoad : WdLoad;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wd_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
`ifdef ULPI_INIT_VERIFY_EN
        rd_d       = 1'b0;
        rd_data_d  = rd_data_q;
`endif

        case (state_q)
            StIdle: begin
                if (auto_q) begin
                    state_d = (POR_WAIT == 16'd0) ? StWrReq : StPorw;
                    idx_d   = 2'd0;
                end else if (start) begin
                    state_d = StWrReq;
                    idx_d   = 2'd0;
                end
            end
            StPorw: begin
                if (tmr_zero) begin
                    state_d = StWrReq;
                    idx_d   = 2'd0;
                end
            end
            StWrReq: begin
                if (!BUSY && !DIR) begin
                    wd_d    = 1'b1;
                    addr_d  = InitAddr[idx_q];
                    wdata_d = InitData[idx_q];
                    state_d = StWrAck;
                end else if (tmr_zero) begin
                    state_d    = StError;
                    err_code_d = ErrAccept;
                    err_idx_d  = idx_q;
                end
            end
            StWrAck: begin
                if (BUSY) begin
                    state_d = StWrEnd;
                end else if (tmr_zero) begin
                    state_d    = StError;
                    err_code_d = ErrAccept;
                    err_idx_d  = idx_q;
                end
            end
            StWrEnd: begin
                if (!BUSY) begin
`ifdef ULPI_INIT_VERIFY_EN
                    state_d = StRdReq;
`else
                    state_d = StNext;
`endif
                end else if (tmr_zero) begin
                    state_d    = StError;
                    err_code_d = ErrComplete;
                    err_idx_d  = idx_q;
                end
            end
`ifdef ULPI_INIT_VERIFY_EN
            StRdReq: begin
                if (!BUSY && !DIR) begin
                    rd_d    = 1'b1;
                    addr_d  = InitAddr[idx_q];
                    state_d = StRdAck;
                end else if (tmr_zero) begin
                    state_d    = StError;
                    err_code_d = ErrAccept;
                    err_idx_d  = idx_q;
                end
            end
            StRdAck: begin
                if (BUSY) begin
                    state_d = StRdEnd;
                end else if (tmr_zero) begin
                    state_d    = StError;
                    err_code_d = ErrAccept;
                    err_idx_d  = idx_q;
                end
            end
            StRdEnd: begin
                if (!BUSY) begin
                    rd_data_d = REG_DATA_OUT;
                    state_d   = StCheck;
                end else if (tmr_zero) begin
                    state_d    = StError;
                    err_code_d = ErrComplete;
                    err_idx_d  = idx_q;
                end
            end
            StCheck: begin
                if (rd_data_q != InitData[idx_q]) begin
                    state_d    = StError;
                    err_code_d = ErrVerify;
                    err_idx_d  = idx_q;
                end else begin
                    state_d = StNext;
                end
            end
`endif
            StNext: begin
                if (idx_q == 2'd3) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StWrReq;
                end
            end
            StDone, StError: begin
                if (start) begin
                    state_d    = StWrReq;
                    idx_d      = 2'd0;
                    err_code_d = ErrNone;
                    err_idx_d  = 2'd0;
                end
            end
            default: state_d = StIdle;
        endcase

        running_d = !(state_d inside {StIdle, StDone, StError});
    end

    always_ff @(posedge clk_ext or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            auto_q     <= AUTO_START;
            wd_q       <= 1'b0;
            addr_q     <= 6'd0;
            wdata_q    <= 8'd0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ErrNone;
            err_idx_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            auto_q     <= 1'b0;
            wd_q       <= wd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            running_q  <= running_d;
            done_q     <= (state_d == StDone);
            error_q    <= (state_d == StError);
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
        end
    end

`ifdef ULPI_INIT_VERIFY_EN
    always_ff @(posedge clk_ext or negedge rst) begin
        if (!rst) begin
            rd_q      <= 1'b0;
            rd_data_q <= 8'd0;
        end else begin
            rd_q      <= rd_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign RD = rd_q;
`else
    logic unused_reg_data;
    assign unused_reg_data = ^REG_DATA_OUT;
    assign RD = 1'b0;
`endif

    assign WD          = wd_q;
    assign ADDR        = addr_q;
    assign REG_DATA_IN = wdata_q;
    assign running     = running_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign err_idx     = err_idx_q;

endmodule
